// File: rtl/ray_aabb_err_scoreboard.sv
// Scores a Ray_AABB core's hit_miss stream against golden bits that are
// delayed by the core latency, counting Type1/Type2 errors per run.
module ray_aabb_err_scoreboard #(
    parameter int unsigned LATENCY   = 34,
    parameter int unsigned NUM_TESTS = 10000,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic             gold_in,
    input  logic             hit_miss,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] type1_err,
    output logic [CNT_W-1:0] type2_err,
    output logic [CNT_W-1:0] gold_hits,
    output logic [CNT_W-1:0] checked
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [31:0]      LAST    = 32'(NUM_TESTS - 1);

    state_t             state_q, state_d;
    logic [LATENCY-1:0] vld_q, vld_d;
    logic [LATENCY-1:0] gold_q, gold_d;
    logic [CNT_W-1:0]   t1_q, t1_d;
    logic [CNT_W-1:0]   t2_q, t2_d;
    logic [CNT_W-1:0]   gh_q, gh_d;
    logic [CNT_W-1:0]   ck_q, ck_d;
    logic               score;
    logic               tap_gold;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                  input logic en);
        return (en && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
    endfunction

    assign tap_gold = gold_q[LATENCY-1];
    // start has priority: the start edge never scores, even mid-run.
    assign score    = (state_q == S_RUN) && !start && vld_q[LATENCY-1];

    always_comb begin
        state_d = state_q;
        t1_d    = t1_q;
        t2_d    = t2_q;
        gh_d    = gh_q;
        ck_d    = ck_q;
        vld_d   = vld_q << 1;
        gold_d  = gold_q << 1;
        if (start) begin
            vld_d = '0;
        end
        vld_d[0]  = in_valid & (start | (state_q == S_RUN));
        gold_d[0] = gold_in;

        if (start) begin
            t1_d    = '0;
            t2_d    = '0;
            gh_d    = '0;
            ck_d    = '0;
            state_d = S_RUN;
        end else if (score) begin
            ck_d = sat_inc(ck_q, 1'b1);
            gh_d = sat_inc(gh_q, tap_gold);
            t1_d = sat_inc(t1_q, tap_gold & ~hit_miss);
            t2_d = sat_inc(t2_q, ~tap_gold & hit_miss);
            if (32'(ck_q) == LAST) begin
                state_d = S_DONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            vld_q   <= '0;
            gold_q  <= '0;
            t1_q    <= '0;
            t2_q    <= '0;
            gh_q    <= '0;
            ck_q    <= '0;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            gold_q  <= gold_d;
            t1_q    <= t1_d;
            t2_q    <= t2_d;
            gh_q    <= gh_d;
            ck_q    <= ck_d;
        end
    end

    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign type1_err = t1_q;
    assign type2_err = t2_q;
    assign gold_hits = gh_q;
    assign checked   = ck_q;

endmodule

// File: tb/tb_ray_aabb_err_scoreboard.sv
// Bench for ray_aabb_err_scoreboard: two configurations driven in parallel,
// checked every cycle against a timestamp-based run model plus directed values.
module tb_ray_aabb_err_scoreboard;

    localparam int MAXC = 8192;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, in_valid = 1'b0, gold_in = 1'b0, hit_miss = 1'b0;

    logic        a_busy, a_done, b_busy, b_done;
    logic [15:0] a_t1, a_t2, a_gh, a_ck;
    logic [3:0]  b_t1, b_t2, b_gh, b_ck;

    ray_aabb_err_scoreboard #(.LATENCY(4), .NUM_TESTS(8), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .gold_in(gold_in), .hit_miss(hit_miss), .busy(a_busy), .done(a_done),
        .type1_err(a_t1), .type2_err(a_t2), .gold_hits(a_gh), .checked(a_ck));

    ray_aabb_err_scoreboard #(.LATENCY(3), .NUM_TESTS(20), .CNT_W(4)) u_b (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .gold_in(gold_in), .hit_miss(hit_miss), .busy(b_busy), .done(b_done),
        .type1_err(b_t1), .type2_err(b_t2), .gold_hits(b_gh), .checked(b_ck));

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: each run remembers which cycle accepted which ray;
    // a ray accepted at cycle p in the current run is scored at cycle p+LAT.
    int lat  [2] = '{4, 3};
    int nt   [2] = '{8, 20};
    int maxc [2] = '{65535, 15};
    bit acc_v [2][MAXC];
    bit acc_g [2][MAXC];
    int m_t1 [2], m_t2 [2], m_gh [2], m_ck [2], m_rs [2];
    bit m_run [2], m_done [2];

    bit dv [MAXC];
    bit dr [MAXC];

    function automatic int sat(input int v, input int m);
        return (v < m) ? v + 1 : v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_t1[k] = 0; m_t2[k] = 0; m_gh[k] = 0; m_ck[k] = 0;
            m_run[k] = 0; m_done[k] = 0; m_rs[k] = 0;
        end
    endtask

    task automatic model_edge();
        int p, pre;
        for (int k = 0; k < 2; k++) begin
            if (start) begin
                m_t1[k] = 0; m_t2[k] = 0; m_gh[k] = 0; m_ck[k] = 0;
                m_run[k] = 1; m_done[k] = 0; m_rs[k] = cyc;
                acc_v[k][cyc] = in_valid;
                acc_g[k][cyc] = gold_in;
            end else if (m_run[k]) begin
                acc_v[k][cyc] = in_valid;
                acc_g[k][cyc] = gold_in;
                p = cyc - lat[k];
                if (p >= m_rs[k] && acc_v[k][p]) begin
                    pre = m_ck[k];
                    m_ck[k] = sat(m_ck[k], maxc[k]);
                    if (acc_g[k][p]) m_gh[k] = sat(m_gh[k], maxc[k]);
                    if (acc_g[k][p] && !hit_miss) m_t1[k] = sat(m_t1[k], maxc[k]);
                    if (!acc_g[k][p] && hit_miss) m_t2[k] = sat(m_t2[k], maxc[k]);
                    if (pre == nt[k] - 1) begin
                        m_run[k] = 0;
                        m_done[k] = 1;
                    end
                end
            end else begin
                acc_v[k][cyc] = 1'b0;
            end
        end
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all();
        chk("a_busy", 32'(a_busy), 32'(m_run[0]));
        chk("a_done", 32'(a_done), 32'(m_done[0]));
        chk("a_type1", 32'(a_t1), 32'(m_t1[0]));
        chk("a_type2", 32'(a_t2), 32'(m_t2[0]));
        chk("a_gold_hits", 32'(a_gh), 32'(m_gh[0]));
        chk("a_checked", 32'(a_ck), 32'(m_ck[0]));
        chk("b_busy", 32'(b_busy), 32'(m_run[1]));
        chk("b_done", 32'(b_done), 32'(m_done[1]));
        chk("b_type1", 32'(b_t1), 32'(m_t1[1]));
        chk("b_type2", 32'(b_t2), 32'(m_t2[1]));
        chk("b_gold_hits", 32'(b_gh), 32'(m_gh[1]));
        chk("b_checked", 32'(b_ck), 32'(m_ck[1]));
    endtask

    task automatic cyc_step(input bit s, input bit v, input bit g, input bit h);
        @(negedge clk);
        start = s; in_valid = v; gold_in = g; hit_miss = h;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // Emulated core with latency 4: reply r for the ray driven 4 cycles ago.
    task automatic rstep(input bit s, input bit v, input bit g, input bit r, input bit rnd_idle);
        bit h;
        int p;
        p = cyc - 4;
        if (p >= 0 && dv[p]) h = dr[p];
        else h = rnd_idle ? 1'($urandom_range(1, 0)) : 1'b0;
        dv[cyc] = v;
        dr[cyc] = r;
        cyc_step(s, v, g, h);
    endtask

    initial begin
        int s0, dc, t0;
        bit gp [8] = '{1, 1, 0, 0, 1, 0, 1, 0};
        bit hp [8] = '{0, 1, 1, 0, 1, 1, 1, 0};
        int gap_pos [8] = '{0, 2, 5, 7, 10, 12, 15, 19};
        int gi;
        bit gg;

        // Reset state
        model_reset();
        #1;
        check_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all();

        // 8 matched gold=1 rays; done latency from the start edge
        s0 = cyc;
        dc = -1;
        rstep(1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) rstep(0, 1, 1, 1, 0);
        for (int i = 0; i < 8; i++) begin
            rstep(0, 0, 0, 0, 0);
            if (a_done && dc < 0) dc = cyc - 1;
        end
        // last ray at s0+8 is scored 4 edges later
        chk("done_edge", 32'(dc - s0), 32'd12);
        chk("t1_checked8", 32'(a_ck), 32'd8);
        chk("t1_gold_hits8", 32'(a_gh), 32'd8);
        chk("t1_err1", 32'(a_t1), 32'd0);
        chk("t1_err2", 32'(a_t2), 32'd0);
        chk("t1_busy", 32'(a_busy), 32'd0);

        // Mixed gold / hit_miss pattern
        rstep(1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) rstep(0, 1, gp[i], hp[i], 0);
        for (int i = 0; i < 6; i++) rstep(0, 0, 0, 0, 0);
        chk("pat_type1", 32'(a_t1), 32'd1);
        chk("pat_type2", 32'(a_t2), 32'd2);
        chk("pat_gold_hits", 32'(a_gh), 32'd4);
        chk("pat_checked", 32'(a_ck), 32'd8);
        chk("pat_done", 32'(a_done), 32'd1);

        // Alignment: hit_miss one cycle early, then exactly on time
        for (int rep = 0; rep < 2; rep++) begin
            cyc_step(1, 0, 0, 0);
            t0 = cyc;
            cyc_step(0, 1, 1, 0);
            while (cyc < t0 + 6) cyc_step(0, 0, 0, (cyc == t0 + 3 + rep));
            chk("align_a_type1", 32'(a_t1), (rep == 0) ? 32'd1 : 32'd0);
            chk("align_a_checked", 32'(a_ck), 32'd1);
            chk("align_b_type1", 32'(b_t1), (rep == 0) ? 32'd0 : 32'd1);
        end

        // Gapped rays with hit_miss toggling in idle slots
        rstep(1, 0, 0, 0, 0);
        gi = 0;
        for (int i = 0; i < 20; i++) begin
            if (gi < 8 && gap_pos[gi] == i) begin
                gg = 1'($urandom_range(1, 0));
                rstep(0, 1, gg, gg, 1);
                gi++;
            end else begin
                rstep(0, 0, 0, 0, 1);
            end
        end
        for (int i = 0; i < 6; i++) rstep(0, 0, 0, 0, 1);
        chk("gap_checked", 32'(a_ck), 32'd8);
        chk("gap_type1", 32'(a_t1), 32'd0);
        chk("gap_type2", 32'(a_t2), 32'd0);

        // Saturation on the 4-bit instance
        cyc_step(1, 0, 0, 1);
        for (int i = 0; i < 30; i++) cyc_step(0, 1, 0, 1);
        for (int i = 0; i < 4; i++) cyc_step(0, 0, 0, 1);
        chk("sat_type2", 32'(b_t2), 32'd15);
        chk("sat_checked", 32'(b_ck), 32'd15);
        chk("sat_busy", 32'(b_busy), 32'd1);
        chk("sat_gold_hits", 32'(b_gh), 32'd0);
        cyc_step(1, 0, 0, 0);
        chk("sat_clr_type2", 32'(b_t2), 32'd0);
        chk("sat_clr_checked", 32'(b_ck), 32'd0);

        // Random runs with occasional mid-run restarts
        for (int run = 0; run < 6; run++) begin
            cyc_step(1, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
            for (int i = 0; i < 80 + int'($urandom_range(40, 0)); i++) begin
                cyc_step(($urandom_range(49, 0) == 0),
                         ($urandom_range(3, 0) != 0),
                         1'($urandom_range(1, 0)),
                         1'($urandom_range(1, 0)));
            end
        end

        // Mid-run start after 3 scores, then asynchronous reset mid-cycle
        rstep(1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) rstep(0, 1, 1, 1, 0);
        chk("mid_checked3", 32'(a_ck), 32'd3);
        rstep(1, 1, 1, 1, 0);
        chk("mid_restart_checked", 32'(a_ck), 32'd0);
        rstep(0, 1, 1, 1, 0);
        rstep(0, 1, 1, 1, 0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        chk("async_busy", 32'(a_busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < MAXC; c++) acc_v[k][c] = 1'b0;
        cyc_step(1, 0, 0, 1);
        for (int i = 0; i < 10; i++) cyc_step(0, 0, 0, 1);
        chk("post_rst_checked", 32'(a_ck), 32'd0);
        chk("post_rst_type2", 32'(a_t2), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
